// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and carry-valid opcode set for alu_bus_sequencer
package alu_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_ADC = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_INC = 3'b011;
    localparam logic [OP_W-1:0] OP_DEC = 3'b100;
    localparam logic [OP_W-1:0] OP_AND = 3'b101;
    localparam logic [OP_W-1:0] OP_OR  = 3'b110;
    localparam logic [OP_W-1:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Only the arithmetic ops report a meaningful carry/borrow.
    function automatic logic op_has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bus_sequencer.sv
// rtl/alu_bus_sequencer.sv - ALU bus initiator: request -> EXEC -> READ -> response
// Optional operand chaining from the last result when ALU_SEQ_CHAIN_EN is defined.
module alu_bus_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OPW-1:0]   req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic             req_chain,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_mode,
    output logic             alu_ee,
    output logic             alu_eo,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             alu_flag_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             busy
);

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_READ;
            ST_READ: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and bus enables decode straight from the state register.
    assign req_ready = (state == ST_IDLE);
    assign alu_ee    = (state == ST_EXEC);
    assign alu_eo    = (state == ST_READ);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

`ifdef ALU_SEQ_CHAIN_EN
    logic [WIDTH-1:0] last_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_result <= '0;
        end else if (state == ST_READ) begin
            last_result <= bus_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
`ifdef ALU_SEQ_CHAIN_EN
                alu_a <= req_chain ? last_result : req_a;
`else
                alu_a <= req_a;
`endif
                alu_b    <= req_b;
                alu_mode <= req_op;
            end
            // Zero is computed from the captured bus value, not the ALU's own flag.
            if (state == ST_READ) begin
                rsp_data  <= bus_in;
                rsp_zero  <= (bus_in == '0);
                rsp_carry <= op_has_carry(alu_mode) & alu_flag_carry;
            end
        end
    end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb/tb_alu_bus_sequencer.sv - directed table-driven bench for alu_bus_sequencer with a behavioural ALU
module tb_alu_bus_sequencer;
    import alu_seq_pkg::*;

    localparam int W   = 8;
    localparam int OPW = 3;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
`ifdef ALU_SEQ_CHAIN_EN
    logic           req_chain;
`endif
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [OPW-1:0] alu_mode;
    logic           alu_ee;
    logic           alu_eo;
    logic [W-1:0]   bus_in;
    logic           alu_flag_carry;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero;
    logic           rsp_carry;
    logic           busy;

    alu_bus_sequencer #(.WIDTH(W), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
`ifdef ALU_SEQ_CHAIN_EN
        .req_chain(req_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_ee(alu_ee), .alu_eo(alu_eo),
        .bus_in(bus_in), .alu_flag_carry(alu_flag_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: registers result/carry on execute, drives the bus only when output-enabled.
    function automatic logic [8:0] alu_fn(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                                          input logic cin);
        case (m)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} + {1'b0, b} + {8'h00, cin};
            3'b010:  return {(a < b), a - b};
            3'b011:  return {(a == 8'hFF), a + 8'h01};
            3'b100:  return {(a == 8'h00), a - 8'h01};
            3'b101:  return {1'b0, a & b};
            3'b110:  return {1'b0, a | b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    logic [7:0] m_res;
    logic       m_c;
    initial begin
        m_res = 8'h00;
        m_c   = 1'b0;
    end
    always @(posedge clk) if (alu_ee) {m_c, m_res} <= alu_fn(alu_mode, alu_a, alu_b, m_c);
    assign bus_in         = alu_eo ? m_res : 8'hA5;
    assign alu_flag_carry = m_c;

    int eo_cycles = 0;
    int overlap   = 0;
    always @(negedge clk) begin
        if (alu_eo) eo_cycles++;
        if (alu_ee && alu_eo) overlap++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request from IDLE, returns the response and the edge count to rsp_valid.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic z, output logic c, output int lat);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) req_valid = 1'b0;
            if (rsp_valid) break;
        end
        d = rsp_data; z = rsp_zero; c = rsp_carry;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs[10];

    logic [7:0] d;
    logic       z, c;
    int         lat;
    int         rnd_bad;

    initial begin
        vecs[0] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{OP_ADC, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0};
        vecs[2] = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        vecs[3] = '{OP_SUB, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[4] = '{OP_INC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{OP_DEC, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[7] = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
        req_chain = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_ee_eo", {alu_ee, alu_eo}, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, d, z, c, lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_data", i), d, vecs[i].d);
            check($sformatf("vec%0d_zero", i), z, vecs[i].z);
            check($sformatf("vec%0d_carry", i), c, vecs[i].c);
        end

        // Backpressure: response held, second request waits until after the handshake.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_op = OP_ADD; req_a = 8'h10; req_b = 8'h20; req_valid = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin req_a = 8'h44; req_b = 8'h01; end
            if (rsp_valid) break;
        end
        check("bp_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_data%0d", k), rsp_data, 8'h30);
            check($sformatf("bp_hold_valid%0d", k), {rsp_valid, req_ready, rsp_zero, rsp_carry}, 4'b1000);
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs", {req_ready, rsp_valid, busy}, 3'b100);
        @(posedge clk); #1;
        check("bp_second_accept", {busy, alu_a}, {1'b1, 8'h44});
        req_valid = 1'b0;
        lat = 0;
        while (lat < 20 && !rsp_valid) begin @(posedge clk); #1; lat++; end
        check("bp_second_data", rsp_data, 8'h45);
        @(posedge clk); #1;

        // Reset while the bus is being read.
        @(negedge clk);
        req_op = OP_ADD; req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_exec_ee", alu_ee, 1);
        @(posedge clk); #1;
        check("rst_read_eo", alu_eo, 1);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_state", {alu_eo, alu_ee, busy, rsp_valid}, 4'b0000);
        check("rst_mid_alu_a", alu_a, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_stale_rsp", rsp_valid, 0);
        run_op(OP_ADD, 8'h01, 8'h02, d, z, c, lat);
        check("post_rst_data", d, 8'h03);
        check("post_rst_latency", lat, 3);

        // Bus discipline over random operations.
        eo_cycles = 0; overlap = 0; rnd_bad = 0;
        for (int i = 0; i < 100; i++) begin
            logic [2:0] rop;
            logic [7:0] ra, rb;
            logic [8:0] exp9;
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            exp9 = alu_fn(rop, ra, rb, m_c);
            run_op(rop, ra, rb, d, z, c, lat);
            if (d !== exp9[7:0] || lat != 3) rnd_bad++;
        end
        check("rand_eo_cycles", eo_cycles, 100);
        check("rand_ee_eo_overlap", overlap, 0);
        check("rand_results", rnd_bad, 0);

`ifdef ALU_SEQ_CHAIN_EN
        run_op(OP_ADD, 8'h01, 8'h01, d, z, c, lat);
        check("chain_first", d, 8'h02);
        req_chain = 1'b1;
        run_op(OP_ADD, 8'h77, 8'h01, d, z, c, lat);
        req_chain = 1'b0;
        check("chain_second", d, 8'h03);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
